spi_frame_sequencer: RTL

Multi-motor SPI frame sequencer for myoControl motor boards. On `start` it runs one sweep over all enabled motors: for each one it selects the slave, pushes a fixed-length command frame into the shared SPI master word interface, and unpacks the status words returned. Per-motor results are presented as one-cycle `frame_valid` records. A per-frame watchdog aborts stalled transfers and flags the motor, and the sweep then moves on.

---
 rtl/spi_frame_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer
//   Sweeps all enabled motors on a shared SPI bus. For each motor it selects
//   the slave, pushes a FRAME_WORDS command frame through the SPI master word
//   interface and unpacks the returned status words into a one-cycle record.
//   A per-word watchdog aborts a stalled frame and flags the motor.
// Ports
//   clock, reset_n          : clock, async active-low reset
//   start, motor_enable     : sweep request / per-motor include mask
//   pwm_ref                 : 16-bit signed setpoint per motor
//   di_req, write_ack, data_read_valid, data_read, ss_n : SPI master side
//   word, wren, motor_sel   : transmit word, write request, slave index
//   busy, sweep_done        : sweep status
//   frame_valid, rec_motor, position..sensor2 : per-motor record
//   error_mask              : sticky timeout flags of the current sweep
module spi_frame_sequencer #(
  parameter int          NUM_MOTORS  = 6,
  parameter int          FRAME_WORDS = 12,
  parameter logic [15:0] HEADER      = 16'h8000,
  parameter int          TIMEOUT     = 2000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [NUM_MOTORS-1:0]      motor_enable,
  input  logic [16*NUM_MOTORS-1:0]   pwm_ref,
  input  logic                       di_req,
  input  logic                       write_ack,
  input  logic                       data_read_valid,
  input  logic [15:0]                data_read,
  input  logic                       ss_n,
  output logic [15:0]                word,
  output logic                       wren,
  output logic [3:0]                 motor_sel,
  output logic                       busy,
  output logic                       sweep_done,
  output logic                       frame_valid,
  output logic [3:0]                 rec_motor,
  output logic signed [31:0]         position,
  output logic signed [15:0]         velocity,
  output logic signed [15:0]         current,
  output logic signed [15:0]         displacement,
  output logic signed [15:0]         sensor1,
  output logic signed [15:0]         sensor2,
  output logic [NUM_MOTORS-1:0]      error_mask
);

  localparam logic [7:0]      FW_C   = 8'(FRAME_WORDS);
  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SELECT, SEND, DRAIN, NEXT} state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 m_q, m_d;
  logic [7:0]                 tx_q, tx_d, rx_q, rx_d;
  logic [WD_W-1:0]            wd_q, wd_d;
  logic                       armed_q, armed_d, first_q, first_d;
  logic [15:0]                word_q, word_d;
  logic                       wren_q, wren_d, busy_q, busy_d, done_q, done_d, fv_q, fv_d;
  logic [3:0]                 sel_q, sel_d, rec_q, rec_d;
  logic [31:0]                pos_q, pos_d;
  logic [15:0]                vel_q, vel_d, cur_q, cur_d, disp_q, disp_d, s1_q, s1_d, s2_q, s2_d;
  logic [NUM_MOTORS-1:0]      err_q, err_d;
  // staging for rx words 5..11; copied to the outputs only on frame_valid
  logic [6:0][15:0]           st_q, st_d;
  // edge detectors: registered pulses plus the word captured alongside
  logic                       ack_d_q, ack_d_d, ack_rise_q, ack_rise_d;
  logic                       drv_d_q, drv_d_d, drv_fall_q, drv_fall_d;
  logic [15:0]                rxw_q, rxw_d;
  logic [4:0]                 nxt, first_pick;
  logic [15:0]                pwm_sel;

  // lowest enabled index strictly above lo; bit 4 = found
  function automatic logic [4:0] pick(input logic [NUM_MOTORS-1:0] en, input int lo);
    logic [4:0] r;
    r = '0;
    for (int i = NUM_MOTORS - 1; i >= 0; i--)
      if (en[i] && i > lo) r = {1'b1, 4'(i)};
    return r;
  endfunction

  always_comb begin
    pwm_sel = '0;
    for (int i = 0; i < NUM_MOTORS; i++)
      if (m_q == 4'(i)) pwm_sel = pwm_ref[16*i +: 16];
  end

  always_comb begin
    state_d = state_q;  m_d = m_q;  tx_d = tx_q;  rx_d = rx_q;  wd_d = wd_q;
    armed_d = armed_q;  first_d = first_q;  word_d = word_q;  wren_d = wren_q;
    sel_d = sel_q;  busy_d = busy_q;  done_d = 1'b0;  fv_d = 1'b0;  rec_d = rec_q;
    pos_d = pos_q;  vel_d = vel_q;  cur_d = cur_q;  disp_d = disp_q;
    s1_d = s1_q;  s2_d = s2_q;  err_d = err_q;  st_d = st_q;
    ack_d_d    = write_ack;
    ack_rise_d = write_ack & ~ack_d_q;
    drv_d_d    = data_read_valid;
    drv_fall_d = ~data_read_valid & drv_d_q;
    rxw_d      = data_read;
    nxt        = pick(motor_enable, int'(m_q));
    first_pick = pick(motor_enable, -1);

    case (state_q)
      IDLE: if (start) begin
        err_d = '0;
        if (first_pick[4]) begin
          m_d = first_pick[3:0];  sel_d = first_pick[3:0];
          busy_d = 1'b1;  state_d = SELECT;
        end else begin
          done_d = 1'b1;
        end
      end
      SELECT: if (ss_n) begin
        tx_d = '0;  rx_d = '0;  wd_d = '0;
        armed_d = 1'b1;  first_d = 1'b1;  state_d = SEND;
      end
      SEND, DRAIN: begin
        wd_d = wd_q + 1'b1;
        if (state_q == SEND) begin
          // armed_q low means a word is outstanding, so only then is an ack meaningful
          if (ack_rise_q && !armed_q) begin
            wren_d = 1'b0;  tx_d = tx_q + 1'b1;  armed_d = 1'b1;  wd_d = '0;
          end else if (armed_q && tx_q < FW_C && (first_q || di_req)) begin
            case (tx_q)
              8'd0:    word_d = HEADER;
              8'd1:    word_d = pwm_sel & 16'h7fff;
              default: word_d = '0;
            endcase
            wren_d = 1'b1;  armed_d = 1'b0;  first_d = 1'b0;  wd_d = '0;
          end
          if (tx_q == FW_C) state_d = DRAIN;
        end
        if (drv_fall_q) begin
          for (int k = 0; k < 7; k++)
            if (rx_q == 8'(k + 5)) st_d[k] = rxw_q;
          if (rx_q != 8'hff) rx_d = rx_q + 1'b1;
        end
        if (state_q == DRAIN && ss_n && rx_q >= 8'd12) begin
          fv_d = 1'b1;  rec_d = m_q;
          pos_d = {st_q[0], st_q[1]};  vel_d = st_q[2];  cur_d = st_q[3];
          disp_d = st_q[4];  s1_d = st_q[5];  s2_d = st_q[6];
          state_d = NEXT;
        end
        // watchdog wins over everything else this cycle
        if (wd_q == WD_MAX) begin
          wren_d = 1'b0;  fv_d = 1'b0;  rec_d = rec_q;
          pos_d = pos_q;  vel_d = vel_q;  cur_d = cur_q;
          disp_d = disp_q;  s1_d = s1_q;  s2_d = s2_q;
          err_d = err_q | (NUM_MOTORS'(1) << m_q);
          state_d = NEXT;
        end
      end
      NEXT: if (nxt[4]) begin
        m_d = nxt[3:0];  sel_d = nxt[3:0];  state_d = SELECT;
      end else begin
        done_d = 1'b1;  busy_d = 1'b0;  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;  m_q <= '0;  tx_q <= '0;  rx_q <= '0;  wd_q <= '0;
      armed_q <= 1'b0;  first_q <= 1'b0;  word_q <= '0;  wren_q <= 1'b0;
      sel_q <= '0;  busy_q <= 1'b0;  done_q <= 1'b0;  fv_q <= 1'b0;  rec_q <= '0;
      pos_q <= '0;  vel_q <= '0;  cur_q <= '0;  disp_q <= '0;  s1_q <= '0;  s2_q <= '0;
      err_q <= '0;  st_q <= '0;
      ack_d_q <= 1'b0;  ack_rise_q <= 1'b0;  drv_d_q <= 1'b0;  drv_fall_q <= 1'b0;
      rxw_q <= '0;
    end else begin
      state_q <= state_d;  m_q <= m_d;  tx_q <= tx_d;  rx_q <= rx_d;  wd_q <= wd_d;
      armed_q <= armed_d;  first_q <= first_d;  word_q <= word_d;  wren_q <= wren_d;
      sel_q <= sel_d;  busy_q <= busy_d;  done_q <= done_d;  fv_q <= fv_d;  rec_q <= rec_d;
      pos_q <= pos_d;  vel_q <= vel_d;  cur_q <= cur_d;  disp_q <= disp_d;
      s1_q <= s1_d;  s2_q <= s2_d;  err_q <= err_d;  st_q <= st_d;
      ack_d_q <= ack_d_d;  ack_rise_q <= ack_rise_d;  drv_d_q <= drv_d_d;
      drv_fall_q <= drv_fall_d;  rxw_q <= rxw_d;
    end
  end

  assign word = word_q;  assign wren = wren_q;  assign motor_sel = sel_q;
  assign busy = busy_q;  assign sweep_done = done_q;  assign frame_valid = fv_q;
  assign rec_motor = rec_q;  assign position = pos_q;  assign velocity = vel_q;
  assign current = cur_q;  assign displacement = disp_q;  assign sensor1 = s1_q;
  assign sensor2 = s2_q;  assign error_mask = err_q;

endmodule
